// File: rtl/count_capture_fifo_if.sv
// Stream bundle for count_capture_fifo: counter-side capture inputs plus the
// valid/ready drain port. The master modport is the FIFO side.
interface count_capture_fifo_if #(
  parameter int WIDTH = 8,
  parameter int TS_W  = 16
);
  logic [WIDTH-1:0] in_count;
  logic             in_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic [TS_W-1:0]  out_stamp;

  modport master (
    input  in_count,
    input  in_done,
    output out_valid,
    input  out_ready,
    output out_count,
    output out_stamp
  );

  modport slave (
    output in_count,
    output in_done,
    input  out_valid,
    output out_ready,
    input  out_count,
    input  out_stamp
  );
endinterface

// File: rtl/count_capture_fifo.sv
// Captures each rising edge of the counter's done flag as a (count, cycle stamp)
// snapshot into a small show-ahead FIFO; overflows are dropped and counted.
module count_capture_fifo #(
  parameter int WIDTH  = 8,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic                     sync_clr,
  count_capture_fifo_if.master     bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [TS_W-1:0]   stamp_q,    stamp_d;
  logic              done_q,     done_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [LVL_W-1:0]  level_q,    level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0]  count_mem_q [DEPTH];
  logic [WIDTH-1:0]  count_mem_d [DEPTH];
  logic [TS_W-1:0]   stamp_mem_q [DEPTH];
  logic [TS_W-1:0]   stamp_mem_d [DEPTH];

  logic rise;
  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign rise     = bus.in_done & ~done_q;
  assign push_req = rise & ~sync_clr;
  assign pop      = bus.out_valid & bus.out_ready;
  assign full     = (level_q == FULL_LVL);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & ~push;

  always_comb begin
    stamp_d     = stamp_q + 1'b1;
    done_d      = bus.in_done;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    count_mem_d = count_mem_q;
    stamp_mem_d = stamp_mem_q;

    if (sync_clr) begin
      stamp_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        count_mem_d[wr_ptr_q] = bus.in_count;
        stamp_mem_d[wr_ptr_q] = stamp_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + 1'b1;
      end else if (pop && !push) begin
        level_d = level_q - 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      stamp_q    <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        count_mem_q[i] <= '0;
        stamp_mem_q[i] <= '0;
      end
    end else begin
      stamp_q     <= stamp_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      count_mem_q <= count_mem_d;
      stamp_mem_q <= stamp_mem_d;
    end
  end

  // Head is read straight from storage, so it holds steady until popped.
  assign bus.out_valid = (level_q != '0);
  assign bus.out_count = count_mem_q[rd_ptr_q];
  assign bus.out_stamp = stamp_mem_q[rd_ptr_q];
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo: reset, capture latency, edge detect,
// overflow, full-with-pop, ordering and synchronous clear.
module tb_count_capture_fifo;

  logic       clk;
  logic       a_rst_n;
  logic       sync_clr;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checks_total;
  int checks_passed;

  count_capture_fifo_if #(.WIDTH(8), .TS_W(16)) bus ();

  count_capture_fifo #(
    .WIDTH(8), .TS_W(16), .DEPTH(4), .DROP_W(8)
  ) dut (
    .clk      (clk),
    .a_rst_n  (a_rst_n),
    .sync_clr (sync_clr),
    .bus      (bus.master),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after an edge, then step one clock and settle.
  task automatic applyStimulus(input logic done, input logic [7:0] count,
                               input logic ready, input logic clr);
    bus.in_done   = done;
    bus.in_count  = count;
    bus.out_ready = ready;
    sync_clr      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    a_rst_n = 1'b0;
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] drain_exp [4];
    checks_total  = 0;
    checks_passed = 0;

    // Reset held with done high and ready high: everything reads zero.
    a_rst_n       = 1'b0;
    sync_clr      = 1'b0;
    bus.in_done   = 1'b1;
    bus.in_count  = 8'h55;
    bus.out_ready = 1'b1;
    #12;
    checkOutput("rst_valid",    32'(bus.out_valid), 32'd0);
    checkOutput("rst_count",    32'(bus.out_count), 32'd0);
    checkOutput("rst_stamp",    32'(bus.out_stamp), 32'd0);
    checkOutput("rst_level",    32'(level),         32'd0);
    checkOutput("rst_overflow", 32'(overflow),      32'd0);
    checkOutput("rst_drop",     32'(drop_cnt),      32'd0);

    // Release with done still high: done_q starts at 0, so exactly one capture.
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_count", 32'(bus.out_count), 32'h55);
    checkOutput("t1_stamp", 32'(bus.out_stamp), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("t1_level_held", 32'(level), 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("t1_level_popped", 32'(level), 32'd0);

    // Rise sampled at the 11th edge after release carries stamp 10.
    bus.in_done = 1'b0;
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h2A, 1'b0, 1'b0);
    checkOutput("t2_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t2_count", 32'(bus.out_count), 32'h2A);
    checkOutput("t2_stamp", 32'(bus.out_stamp), 32'd10);
    checkOutput("t2_level", 32'(level),         32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t2_level_popped", 32'(level),         32'd0);
    checkOutput("t2_valid_popped", 32'(bus.out_valid), 32'd0);

    // Done held high for five cycles gives a single entry.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("t3_level", 32'(level),         32'd1);
    checkOutput("t3_drop",  32'(drop_cnt),      32'd0);
    checkOutput("t3_count", 32'(bus.out_count), 32'h33);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t3_level_popped", 32'(level), 32'd0);

    // Six pulses into a four-deep FIFO: two dropped, first four kept in order.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'(k), 1'b0, 1'b0);
    end
    checkOutput("t4_level",    32'(level),         32'd4);
    checkOutput("t4_overflow", 32'(overflow),      32'd1);
    checkOutput("t4_drop",     32'(drop_cnt),      32'd2);
    checkOutput("t4_head",     32'(bus.out_count), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("t4_drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("t4_drain%0d", k),       32'(bus.out_count), 32'(k));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("t4_level_empty", 32'(level), 32'd0);

    // Full FIFO with a pop and a push together: both happen, nothing dropped.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(8'h11 + k), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("t5_level_full", 32'(level), 32'd4);
    applyStimulus(1'b1, 8'h09, 1'b1, 1'b0);
    checkOutput("t5_level_still_full", 32'(level),    32'd4);
    checkOutput("t5_drop_unchanged",   32'(drop_cnt), 32'd2);
    drain_exp[0] = 8'h12;
    drain_exp[1] = 8'h13;
    drain_exp[2] = 8'h14;
    drain_exp[3] = 8'h09;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t5_drain%0d", k), 32'(bus.out_count), 32'(drain_exp[k]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("t5_level_empty", 32'(level), 32'd0);

    // Clear with done held high wipes state and suppresses the held done.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(8'h21 + k), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("t6_level_pre",    32'(level),    32'd3);
    checkOutput("t6_overflow_pre", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("t6_level",    32'(level),         32'd0);
    checkOutput("t6_valid",    32'(bus.out_valid), 32'd0);
    checkOutput("t6_overflow", 32'(overflow),      32'd0);
    checkOutput("t6_drop",     32'(drop_cnt),      32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("t6_no_capture", 32'(level), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("t6_recapture_level", 32'(level),         32'd1);
    checkOutput("t6_recapture_count", 32'(bus.out_count), 32'h44);
    checkOutput("t6_recapture_stamp", 32'(bus.out_stamp), 32'd4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
